// File: rtl/vga_timing_gen.sv
// Video timing generator: pixel-enable divider, h/v counters, registered sync/blank
// decode, run/stop that only takes effect on a frame boundary, and a frame counter.
module vga_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_BOTTOM   = 10,
    parameter int V_SYNC     = 2,
    parameter int V_TOP      = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIX_DIV    = 1,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          pix_en,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt,
    output logic          busy
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam int HS_BEG  = H_DISPLAY + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_DISPLAY + V_BOTTOM;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div, div_n;
    logic          first, first_n;
    logic [CW-1:0] hpos_n, vpos_n;
    logic          busy_n, pix_n, ls_n, fs_n;
    logic [15:0]   fc_n;
    logic          tick;
    logic          hs_act_n, vs_act_n, de_n;

    assign tick = (state == ACTIVE) && (div == DIV_LAST);

    always_comb begin
        state_n = state;
        div_n   = div;
        first_n = first;
        hpos_n  = hpos;
        vpos_n  = vpos;
        busy_n  = busy;
        pix_n   = 1'b0;
        ls_n    = 1'b0;
        fs_n    = 1'b0;
        fc_n    = frame_cnt;
        case (state)
            IDLE: begin
                div_n  = '0;
                hpos_n = '0;
                vpos_n = '0;
                busy_n = 1'b0;
                if (run) begin
                    state_n = ACTIVE;
                    first_n = 1'b1;
                end
            end
            ACTIVE: begin
                div_n = tick ? '0 : div + 1'b1;
                if (tick) begin
                    pix_n = 1'b1;
                    if (first) begin
                        // First pixel after IDLE shows (0,0) rather than advancing
                        first_n = 1'b0;
                        busy_n  = 1'b1;
                        ls_n    = 1'b1;
                        fs_n    = 1'b1;
                    end else if (hpos == H_LAST) begin
                        hpos_n = '0;
                        ls_n   = 1'b1;
                        if (vpos == V_LAST) begin
                            vpos_n = '0;
                            fc_n   = frame_cnt + 16'd1;
                            if (run) begin
                                fs_n = 1'b1;
                            end else begin
                                state_n = IDLE;
                                div_n   = '0;
                                busy_n  = 1'b0;
                                pix_n   = 1'b0;
                                ls_n    = 1'b0;
                            end
                        end else begin
                            vpos_n = vpos + 1'b1;
                        end
                    end else begin
                        hpos_n = hpos + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Decode from the next counter values so registered outputs line up with hpos/vpos
    always_comb begin
        hs_act_n = (int'(hpos_n) >= HS_BEG) && (int'(hpos_n) < HS_END);
        vs_act_n = (int'(vpos_n) >= VS_BEG) && (int'(vpos_n) < VS_END);
        de_n     = busy_n && (int'(hpos_n) < H_DISPLAY) && (int'(vpos_n) < V_DISPLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            div         <= '0;
            first       <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            busy        <= 1'b0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
        end else begin
            state       <= state_n;
            div         <= div_n;
            first       <= first_n;
            hpos        <= hpos_n;
            vpos        <= vpos_n;
            busy        <= busy_n;
            pix_en      <= pix_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
            frame_cnt   <= fc_n;
            hsync       <= hs_act_n ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vs_act_n ? V_SYNC_POL : ~V_SYNC_POL;
            display_on  <= de_n;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing with a short frame,
// plus a second instance with PIX_DIV=2 and active-high syncs on a tiny raster.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset;
    logic run_a, run_b;

    always #5 clk = ~clk;

    logic       hs_a, vs_a, de_a, pe_a, ls_a, fs_a, busy_a;
    logic [9:0] hpos_a, vpos_a;
    logic [15:0] fc_a;
    logic       hs_b, vs_b, de_b, pe_b, ls_b, fs_b, busy_b;
    logic [9:0] hpos_b, vpos_b;
    logic [15:0] fc_b;

    // A: 800-clk lines, 8 lines (display 0..3, bottom 4, vsync 5..6, top 7)
    vga_timing_gen #(
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1)
    ) dut_a (
        .clk(clk), .reset(reset), .run(run_a),
        .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
        .hpos(hpos_a), .vpos(vpos_a), .pix_en(pe_a),
        .line_start(ls_a), .frame_start(fs_a),
        .frame_cnt(fc_a), .busy(busy_a)
    );

    // B: 23 pixels/line (hsync 18..20), 8 lines (vsync 5..6), 2 clks/pixel
    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(2)
    ) dut_b (
        .clk(clk), .reset(reset), .run(run_b),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
        .hpos(hpos_b), .vpos(vpos_b), .pix_en(pe_b),
        .line_start(ls_b), .frame_start(fs_b),
        .frame_cnt(fc_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    int f_len, hs_cnt0, hs_bad, de_cnt0, de_cnt4, de_bad;
    int vs_cnt, vs_bad, ls_cnt, ls_bad, pe_bad, idle_bad, lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one frame of A from a frame_start sample to the next frame_start (or stop).
    // mode 0: plain, 1: short run=0 glitch mid-frame, 2: run=0 mid-frame (stop).
    task automatic measure_a(input int mode);
        int last_ls, glitch_left;
        f_len = 0; hs_cnt0 = 0; hs_bad = 0; de_cnt0 = 0; de_cnt4 = 0; de_bad = 0;
        vs_cnt = 0; vs_bad = 0; ls_cnt = 0; ls_bad = 0; pe_bad = 0;
        last_ls = -1; glitch_left = 0;
        while (f_len < 10000) begin
            if (f_len > 0 && (fs_a || !busy_a)) break;
            if (vpos_a == 0 && !hs_a) hs_cnt0++;
            if ((!hs_a) != (hpos_a >= 656 && hpos_a < 752)) hs_bad++;
            if (vpos_a == 0 && de_a) de_cnt0++;
            if (vpos_a == 4 && de_a) de_cnt4++;
            if (de_a != (hpos_a < 640 && vpos_a < 4)) de_bad++;
            if (!vs_a) vs_cnt++;
            if ((!vs_a) != (vpos_a == 5 || vpos_a == 6)) vs_bad++;
            if (ls_a) begin
                ls_cnt++;
                if (hpos_a != 0 || (last_ls >= 0 && f_len - last_ls != 800)) ls_bad++;
                last_ls = f_len;
            end
            if (!pe_a) pe_bad++;
            if (vpos_a == 2 && hpos_a == 0 && mode == 1) begin
                run_a = 1'b0;
                glitch_left = 3;
            end else if (glitch_left > 0) begin
                glitch_left--;
                if (glitch_left == 0) run_a = 1'b1;
            end
            if (vpos_a == 2 && hpos_a == 0 && mode == 2) run_a = 1'b0;
            step();
            f_len++;
        end
    endtask

    initial begin
        reset = 1'b0;
        run_a = 1'b0;
        run_b = 1'b0;
        repeat (3) step();

        // Reset values: {hsync,vsync,display_on,pix_en,line_start,frame_start,busy}
        check("rst_a_flags", {hs_a, vs_a, de_a, pe_a, ls_a, fs_a, busy_a}, 7'b1100000);
        check("rst_a_pos", {hpos_a, vpos_a}, 20'd0);
        check("rst_a_fcnt", fc_a, 16'd0);
        check("rst_b_flags", {hs_b, vs_b, de_b, pe_b, ls_b, fs_b, busy_b}, 7'b0000000);
        check("rst_b_fcnt", fc_b, 16'd0);

        reset = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (busy_a || pe_a || fs_a || ls_a || de_a || !hs_a || !vs_a ||
                hpos_a != 0 || vpos_a != 0) idle_bad++;
        end
        check("idle_1000", idle_bad, 0);

        // Start A: run sampled at the next edge, first pixel one edge later
        run_a = 1'b1;
        lat = 0;
        do begin step(); lat++; end while (!fs_a && lat < 50);
        check("a_start_lat", lat, 2);
        check("a_first_px", {pe_a, ls_a, busy_a, de_a, hpos_a, vpos_a}, {4'b1111, 20'd0});

        measure_a(0);
        check("a_f1_len", f_len, 6400);
        check("a_hs_low_line0", hs_cnt0, 96);
        check("a_hs_decode", hs_bad, 0);
        check("a_de_line0", de_cnt0, 640);
        check("a_de_bottom", de_cnt4, 0);
        check("a_de_decode", de_bad, 0);
        check("a_vs_low", vs_cnt, 1600);
        check("a_vs_decode", vs_bad, 0);
        check("a_ls_count", ls_cnt, 8);
        check("a_ls_period", ls_bad, 0);
        check("a_pe_const", pe_bad, 0);
        check("a_fcnt1", fc_a, 16'd1);
        check("a_wrap_pos", {ls_a, hpos_a, vpos_a}, {1'b1, 20'd0});

        measure_a(1);
        check("a_glitch_len", f_len, 6400);
        check("a_glitch_fs", fs_a, 1'b1);
        check("a_fcnt2", fc_a, 16'd2);

        measure_a(2);
        check("a_stop_len", f_len, 6400);
        check("a_stop_fcnt", fc_a, 16'd3);
        check("a_stop_state", {busy_a, pe_a, fs_a, ls_a, de_a, hpos_a, vpos_a}, 25'd0);
        idle_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (busy_a || fs_a || pe_a) idle_bad++;
        end
        check("a_stop_idle", idle_bad, 0);
        check("a_stop_fcnt_hold", fc_a, 16'd3);

        run_a = 1'b1;
        lat = 0;
        do begin step(); lat++; end while (!fs_a && lat < 50);
        check("a_restart_lat", lat, 2);
        check("a_restart_fcnt", fc_a, 16'd3);

        // Async reset mid-frame at (300,2), observed before any further clock edge
        lat = 0;
        while (!(hpos_a == 300 && vpos_a == 2) && lat < 8000) begin step(); lat++; end
        check("a_reach_300_2", {hpos_a, vpos_a}, {10'd300, 10'd2});
        #1 reset = 1'b0;
        #1;
        check("async_rst_flags", {hs_a, vs_a, de_a, pe_a, ls_a, fs_a, busy_a}, 7'b1100000);
        check("async_rst_pos", {hpos_a, vpos_a}, 20'd0);
        check("async_rst_fcnt", fc_a, 16'd0);
        run_a = 1'b0;
        step();
        step();
        reset = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy_a || pe_a || hpos_a != 0) idle_bad++;
        end
        check("post_rst_idle", idle_bad, 0);

        // B: divided pixel clock, active-high syncs
        run_b = 1'b1;
        lat = 0;
        do begin step(); lat++; end while (!fs_b && lat < 50);
        check("b_start_lat", lat, 3);
        check("b_first_px", {hs_b, vs_b, de_b, ls_b, busy_b}, 5'b00111);

        f_len = 0; hs_cnt0 = 0; hs_bad = 0; vs_cnt = 0; pe_bad = 0;
        while (f_len < 2000) begin
            if (f_len > 0 && fs_b) break;
            if (vpos_b == 0 && hs_b) hs_cnt0++;
            if (hs_b != (hpos_b >= 18 && hpos_b < 21)) hs_bad++;
            if (vs_b) vs_cnt++;
            if (pe_b != (f_len % 2 == 0)) pe_bad++;
            step();
            f_len++;
        end
        check("b_frame_len", f_len, 368);
        check("b_hs_high_line0", hs_cnt0, 6);
        check("b_hs_decode", hs_bad, 0);
        check("b_vs_high", vs_cnt, 92);
        check("b_pe_alt", pe_bad, 0);
        check("b_fcnt1", fc_b, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised video timing generator; successor to the fixed-polarity, free-running hvsync generator used by the test_hvsync designs. It adds configurable sync polarity, an internal pixel-clock-enable divider, a run/stop control that stops only on a frame boundary, line/frame strobes and a frame counter. It sits between the system clock and any pixel-generation logic and drives the board hsync/vsync pins.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, right border (front porch) pixels
- H_SYNC, 96, hsync pulse width in pixels
- H_BACK, 48, left border (back porch) pixels
- V_DISPLAY, 480, visible lines per frame
- V_BOTTOM, 10, bottom border (front porch) lines
- V_SYNC, 2, vsync pulse width in lines
- V_TOP, 33, top border (back porch) lines
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level (0 = active-low)
- PIX_DIV, 1, system clocks per pixel (≥1)
- CW, 10, hpos/vpos width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  1 = generate frames; 0 = stop at next frame boundary
- hsync  out  1  horizontal sync at H_SYNC_POL level when active
- vsync  out  1  vertical sync at V_SYNC_POL level when active
- display_on  out  1  hpos < H_DISPLAY and vpos < V_DISPLAY
- hpos  out  CW  current pixel column
- vpos  out  CW  current line
- pix_en  out  1  one-clk pixel strobe; counters advance only on it
- line_start  out  1  one-clk pulse, coincident with pix_en when hpos becomes 0
- frame_start  out  1  one-clk pulse, coincident with pix_en when (hpos,vpos) becomes (0,0)
- frame_cnt  out  16  completed-frame counter, wraps 0xFFFF→0
- busy  out  1  1 while a frame is in progress

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP.
- Horizontal order: display [0,H_DISPLAY), front, sync [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC), back. Vertical order likewise: display, bottom, sync, top.
- Divider: counts 0..PIX_DIV-1 free-running while busy; pix_en=1 at terminal count. PIX_DIV=1 → pix_en constant 1 while busy.
- On pix_en: hpos increments; at H_TOTAL-1 wraps to 0 and vpos increments; vpos wraps at V_TOTAL-1 to 0; frame_cnt increments at that wrap.
- State machine: IDLE, ACTIVE.
  - IDLE: hpos=vpos=0, syncs inactive, display_on=0, pix_en=0, busy=0, divider held at 0. run=1 → ACTIVE next clk; first pix_en after PIX_DIV clks, with frame_start and line_start asserted, and (0,0) shown from that clk on.
  - ACTIVE: at frame wrap (last pixel of last line, pix_en): run=1 → continue (frame_start pulses); run=0 → IDLE, no frame_start.
  - run deasserted mid-frame: frame completes; frame_cnt still increments.
- hsync, vsync, display_on decoded from the registered counters; all outputs registered and mutually consistent with hpos/vpos on the same clk.
- Sync active regions independent of display_on (vsync spans full lines incl. hsync).

## Timing
- Reset (async assert, sync deassert by system): state IDLE, hpos=vpos=0, hsync=~H_SYNC_POL, vsync=~V_SYNC_POL, display_on=0, pix_en=0, line_start=0, frame_start=0, frame_cnt=0, busy=0.
- Reset mid-frame: all outputs to reset values immediately (asynchronously); restart only via run=1 after release.
- Latency run↑ (IDLE) → first pix_en/frame_start: PIX_DIV+1 clks.
- Pixel period exactly PIX_DIV clks; line period H_TOTAL×PIX_DIV; frame period H_TOTAL×V_TOTAL×PIX_DIV.
- run is sampled only at frame wrap in ACTIVE and every clk in IDLE; glitches mid-frame have no effect.
- frame_cnt updates in the same clk as the wrap to (0,0).

## Test plan
- Reset with run=0, defaults: all outputs at reset values; hsync=vsync=1; stays IDLE for 1000 clks.
- run=1, PIX_DIV=1: hsync low exactly for hpos 656..751 (96 clks), line_start every 800 clks, display_on high 640 clks per visible line.
- Full frame: vsync low for vpos 490..491 (1600 clks), frame_start every 420000 clks, frame_cnt 0→1→2.
- PIX_DIV=2, H_SYNC_POL=V_SYNC_POL=1: pix_en every 2nd clk, hsync high 192 clks, frame period 840000 clks.
- run=0 at vpos=100: frame completes, frame_cnt increments once, then hpos=vpos=0, busy=0, no frame_start; run=1 again restarts after PIX_DIV+1 clks.
- reset asserted at hpos=300,vpos=200: outputs return to reset values without waiting for clk; frame_cnt=0.
